// File: rtl/soc_pkg.sv
// Shared constants and types for the RV32 simulation SoC.
package soc_pkg;

  localparam int          IM_WORDS = 16384;
  localparam int          DM_WORDS = 16384;
  localparam int          SRAM_AW  = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BASE  = 32'h0001_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [11:0] CSR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH = 12'hC80;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ls_size_e;

  // Bit layout mirrors funct3 of RV32 loads/stores: {unsigned, size}.
  typedef struct packed {
    logic     uns;
    ls_size_e size;
  } ls_op_t;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, ($signed(a) < $signed(b))};
      3'd3:    return {31'b0, (a < b)};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

endpackage

// File: rtl/cpu.sv
// Multi-cycle RV32I core: fetch, execute, optional load-writeback state.
// 2 cycles per instruction, 3 for loads (covers the SRAM read latency).
// Memories never stall, so the core has no ready inputs.
module cpu import soc_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_vld,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdat,
  output logic        dmem_vld,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdat,
  output ls_op_t      dmem_op,
  input  logic [31:0] dmem_rdat,
  input  logic [63:0] mcycle
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [4:0]  rd_q;
  logic [31:0] rf [32];

  logic [31:0] ins, rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        taken;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dat;

  assign ins   = imem_rdat;
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign rs1v  = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
  assign rs2v  = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0:    taken = (rs1v == rs2v);
      3'd1:    taken = (rs1v != rs2v);
      3'd4:    taken = ($signed(rs1v) <  $signed(rs2v));
      3'd5:    taken = ($signed(rs1v) >= $signed(rs2v));
      3'd6:    taken = (rs1v <  rs2v);
      3'd7:    taken = (rs1v >= rs2v);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    wb_en        = 1'b0;
    wb_rd        = ins[11:7];
    wb_dat       = 32'd0;
    imem_vld     = (state == S_FETCH);
    imem_addr    = pc;
    dmem_vld     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = rs1v + ((opc == 7'h23) ? imm_s : imm_i);
    dmem_wdat    = rs2v;
    dmem_op.uns  = f3[2];
    dmem_op.size = ls_size_e'(f3[1:0]);
    case (state)
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc + 32'd4;
        wb_en   = 1'b1;
        case (opc)
          7'h37: wb_dat = imm_u;
          7'h17: wb_dat = pc + imm_u;
          7'h6F: begin wb_dat = pc + 32'd4; pc_n = pc + imm_j; end
          7'h67: begin wb_dat = pc + 32'd4; pc_n = (rs1v + imm_i) & ~32'd1; end
          7'h63: begin wb_en = 1'b0; if (taken) pc_n = pc + imm_b; end
          // Load holds PC here and advances it once the data returns.
          7'h03: begin wb_en = 1'b0; dmem_vld = 1'b1; pc_n = pc; state_n = S_LOAD; end
          7'h23: begin wb_en = 1'b0; dmem_vld = 1'b1; dmem_we = 1'b1; end
          7'h13: wb_dat = alu(f3, (f3 == 3'd5) && ins[30], rs1v, imm_i);
          7'h33: wb_dat = alu(f3, ins[30], rs1v, rs2v);
          7'h73: wb_dat = (ins[31:20] == CSR_CYCLEH) ? mcycle[63:32] :
                          (ins[31:20] == CSR_CYCLE)  ? mcycle[31:0]  : 32'd0;
          default: wb_en = 1'b0;
        endcase
      end
      S_LOAD: begin
        state_n = S_FETCH;
        pc_n    = pc + 32'd4;
        wb_en   = 1'b1;
        wb_rd   = rd_q;
        wb_dat  = dmem_rdat;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      rd_q  <= 5'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state == S_EXEC) rd_q <= ins[11:7];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_en && (wb_rd != 5'd0)) rf[wb_rd] <= wb_dat;
  end

endmodule

// File: rtl/sram_macro.sv
// Behavioural single-port SRAM macro, 512 rows x 32 words x 32 bits.
// Read data valid one cycle after CEB low; DO holds between reads; no backpressure.
// Contents are only changed by writes or hierarchical backdoor, never by reset.
module sram_macro import soc_pkg::*; (
  input  logic               CLK,
  input  logic               CEB,
  input  logic               WEB,
  input  logic [31:0]        BWEB,
  input  logic [SRAM_AW-1:0] A,
  input  logic [31:0]        DI,
  output logic [31:0]        DO
);

  logic [31:0] MEMORY [0:511][0:31];

  always @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB)
        MEMORY[A[SRAM_AW-1:5]][A[4:0]] <= (MEMORY[A[SRAM_AW-1:5]][A[4:0]] & BWEB) | (DI & ~BWEB);
      else
        DO <= MEMORY[A[SRAM_AW-1:5]][A[4:0]];
    end
  end

endmodule

// File: rtl/sram_wrapper.sv
// SoC-facing wrapper for one 64 KiB SRAM macro instance.
// 1-cycle read latency; always accepts, no backpressure.
// CEB/WEB/BWEB are active-low, passed straight through.
module sram_wrapper import soc_pkg::*; (
  input  logic               clk,
  input  logic               ceb,
  input  logic               web,
  input  logic [31:0]        bweb,
  input  logic [SRAM_AW-1:0] a,
  input  logic [31:0]        di,
  output logic [31:0]        dout
);

  sram_macro i_SRAM (
    .CLK  (clk),
    .CEB  (ceb),
    .WEB  (web),
    .BWEB (bweb),
    .A    (a),
    .DI   (di),
    .DO   (dout)
  );

endmodule

// File: rtl/soc_top.sv
// RV32 simulation top: core, IM1/DM1 SRAMs, data decode, byte lanes, load align, mcycle.
// Fetch and data reads return one cycle after request; IM1 and DM1 run in parallel.
// No backpressure: reset gates every SRAM request, so in-flight stores are dropped.
module soc_top import soc_pkg::*; (
  input logic clk,
  input logic rst
);

  logic        imem_vld;
  logic [31:0] imem_addr, imem_rdat;
  logic        dmem_vld, dmem_we;
  logic [31:0] dmem_addr, dmem_wdat, dmem_rdat;
  ls_op_t      dmem_op;
  logic [63:0] mcycle;

  logic        im_ceb, dm_ceb, dm_sel;
  logic [3:0]  be;
  logic [31:0] dm_bweb, dm_di, dm_do;
  logic        ld_sel;
  ls_op_t      ld_op;
  logic [1:0]  ld_off;
  logic [31:0] ld_sh;
  logic        unused_imem;

  assign unused_imem = ^{imem_addr[31:16], imem_addr[1:0]};

  cpu u_cpu (
    .clk       (clk),
    .rst       (rst),
    .imem_vld  (imem_vld),
    .imem_addr (imem_addr),
    .imem_rdat (imem_rdat),
    .dmem_vld  (dmem_vld),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdat (dmem_wdat),
    .dmem_op   (dmem_op),
    .dmem_rdat (dmem_rdat),
    .mcycle    (mcycle)
  );

  always_ff @(posedge clk) begin
    if (rst) mcycle <= 64'd0;
    else     mcycle <= mcycle + 64'd1;
  end

  assign im_ceb = rst | ~imem_vld;

  sram_wrapper IM1 (
    .clk  (clk),
    .ceb  (im_ceb),
    .web  (1'b1),
    .bweb ('1),
    .a    (imem_addr[15:2]),
    .di   ('0),
    .dout (imem_rdat)
  );

  assign dm_sel = (dmem_addr[31:16] == DM_BASE[31:16]);

  // Misaligned halves/words leave be at zero, which turns the store into a no-op.
  always_comb begin
    be    = 4'b0000;
    dm_di = dmem_wdat;
    case (dmem_op.size)
      SZ_BYTE: begin
        be    = 4'b0001 << dmem_addr[1:0];
        dm_di = {4{dmem_wdat[7:0]}};
      end
      SZ_HALF: begin
        if (!dmem_addr[0]) be = dmem_addr[1] ? 4'b1100 : 4'b0011;
        dm_di = {2{dmem_wdat[15:0]}};
      end
      SZ_WORD: if (dmem_addr[1:0] == 2'b00) be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign dm_bweb = ~{{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign dm_ceb  = rst | ~(dmem_vld & dm_sel & (~dmem_we | (be != 4'b0000)));

  sram_wrapper DM1 (
    .clk  (clk),
    .ceb  (dm_ceb),
    .web  (~dmem_we),
    .bweb (dm_bweb),
    .a    (dmem_addr[15:2]),
    .di   (dm_di),
    .dout (dm_do)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_sel <= 1'b0;
      ld_op  <= '{uns: 1'b0, size: SZ_WORD};
      ld_off <= 2'b00;
    end else if (dmem_vld && !dmem_we) begin
      ld_sel <= dm_sel;
      ld_op  <= dmem_op;
      ld_off <= dmem_addr[1:0];
    end
  end

  assign ld_sh = (ld_sel ? dm_do : 32'd0) >> {ld_off, 3'b000};

  always_comb begin
    dmem_rdat = ld_sh;
    case (ld_op.size)
      SZ_BYTE: dmem_rdat = {{24{~ld_op.uns & ld_sh[7]}},  ld_sh[7:0]};
      SZ_HALF: dmem_rdat = {{16{~ld_op.uns & ld_sh[15]}}, ld_sh[15:0]};
      default: dmem_rdat = ld_sh;
    endcase
  end

endmodule

// File: tb/tb_soc_top.sv
// Directed program-level bench for soc_top: backdoor-loaded programs, DM results checked.
module tb_soc_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] prog_a [4];
  logic [31:0] prog_b [37];
  logic [31:0] c0, c1;

  always #5 clk = ~clk;

  soc_top dut (.clk(clk), .rst(rst));

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] csr_rd(input logic [11:0] csr, input logic [4:0] rd);
    return {csr, 5'd0, 3'b010, rd, 7'h73};
  endfunction

  function automatic logic [31:0] dm(input int w);
    return dut.DM1.i_SRAM.MEMORY[w / 32][w % 32];
  endfunction

  function automatic logic [31:0] im(input int w);
    return dut.IM1.i_SRAM.MEMORY[w / 32][w % 32];
  endfunction

  task automatic poke_im(input int w, input logic [31:0] v);
    dut.IM1.i_SRAM.MEMORY[w / 32][w % 32] <= v;
  endtask

  task automatic poke_dm(input int w, input logic [31:0] v);
    dut.DM1.i_SRAM.MEMORY[w / 32][w % 32] <= v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dm(input int w, input logic [31:0] v, input int budget, input string tag);
    int k;
    k = 0;
    while (dm(w) !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, dm(w), v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_a[0] = u_t(20'h00010, 5'd2);
    prog_a[1] = i_t(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    prog_a[2] = s_t(12'd0, 5'd1, 5'd2, 3'd2);
    prog_a[3] = 32'h0000006F;

    prog_b[0]  = u_t(20'h00010, 5'd2);
    prog_b[1]  = i_t(12'h0AB, 5'd0, 3'd0, 5'd3, 7'h13);
    prog_b[2]  = s_t(12'h001, 5'd3, 5'd2, 3'd0);
    prog_b[3]  = u_t(20'h00001, 5'd4);
    prog_b[4]  = i_t(12'h234, 5'd4, 3'd0, 5'd4, 7'h13);
    prog_b[5]  = s_t(12'h006, 5'd4, 5'd2, 3'd1);
    prog_b[6]  = i_t(12'h008, 5'd2, 3'd0, 5'd5, 7'h03);
    prog_b[7]  = s_t(12'h00C, 5'd5, 5'd2, 3'd2);
    prog_b[8]  = i_t(12'h008, 5'd2, 3'd4, 5'd6, 7'h03);
    prog_b[9]  = s_t(12'h010, 5'd6, 5'd2, 3'd2);
    prog_b[10] = s_t(12'h040, 5'd5, 5'd0, 3'd2);
    prog_b[11] = u_t(20'h00020, 5'd7);
    prog_b[12] = i_t(12'h000, 5'd7, 3'd2, 5'd8, 7'h03);
    prog_b[13] = s_t(12'h014, 5'd8, 5'd2, 3'd2);
    prog_b[14] = i_t(12'h055, 5'd0, 3'd0, 5'd9, 7'h13);
    prog_b[15] = s_t(12'h01A, 5'd9, 5'd2, 3'd0);
    prog_b[16] = s_t(12'h01B, 5'd4, 5'd2, 3'd1);
    prog_b[17] = csr_rd(12'hC00, 5'd10);
    for (int i = 18; i < 28; i++) prog_b[i] = 32'h00000013;
    prog_b[28] = csr_rd(12'hC00, 5'd11);
    prog_b[29] = csr_rd(12'hC80, 5'd12);
    prog_b[30] = s_t(12'h01C, 5'd10, 5'd2, 3'd2);
    prog_b[31] = s_t(12'h020, 5'd11, 5'd2, 3'd2);
    prog_b[32] = s_t(12'h024, 5'd12, 5'd2, 3'd2);
    prog_b[33] = i_t(12'hFFF, 5'd0, 3'd0, 5'd15, 7'h13);
    prog_b[34] = u_t(20'h00020, 5'd16);
    prog_b[35] = s_t(12'hFFC, 5'd15, 5'd16, 3'd2);
    prog_b[36] = 32'h0000006F;

    // Program A: reset, first fetch and a simple word store.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) poke_im(i, prog_a[i]);
    for (int i = 0; i < 17; i++) poke_dm(i, 32'd0);
    poke_dm(16'h3FFF, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_pc", dut.u_cpu.pc, 64'h0);
    check("rst_mcycle", dut.mcycle, 64'h0);
    check("rst_im_ceb", dut.IM1.ceb, 64'h1);
    check("rst_dm_ceb", dut.DM1.ceb, 64'h1);

    rst = 1'b0;
    @(negedge clk);
    check("mcycle_first", dut.mcycle, 64'h1);
    check("first_fetch_word", dut.IM1.dout, {32'h0, prog_a[0]});
    wait_dm(0, 32'h00000005, 200, "a_dm0_addi_sw");

    // Mid-run reset: PC returns, memory written so far is kept.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pc", dut.u_cpu.pc, 64'h0);
    check("midrst_mcycle", dut.mcycle, 64'h0);
    check("midrst_dm_keep", dm(0), 64'h5);

    // Program B: lanes, load extension, out-of-range, misaligned, counter, completion.
    for (int i = 0; i < 37; i++) poke_im(i, prog_b[i]);
    for (int i = 0; i < 17; i++) poke_dm(i, 32'd0);
    poke_dm(2, 32'h000000F0);
    poke_dm(5, 32'hDEADBEEF);
    poke_dm(6, 32'h11223344);
    poke_dm(16'h3FFF, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_dm(16'h3FFF, 32'hFFFFFFFF, 2000, "done_marker");

    check("sb_lane1", dm(0), 64'h0000AB00);
    check("sh_upper", dm(1), 64'h12340000);
    check("dm2_src_kept", dm(2), 64'h000000F0);
    check("lb_sext", dm(3), 64'hFFFFFFF0);
    check("lbu_zext", dm(4), 64'h000000F0);
    check("load_oor_zero", dm(5), 64'h0);
    check("sb_lane2_and_sh_misaligned_drop", dm(6), 64'h11553344);
    check("im_unchanged_w16", im(16), {32'h0, prog_b[16]});
    check("oor_store_not_in_dm", dm(16), 64'h0);
    c0 = dm(7);
    c1 = dm(8);
    check("cycle_diff_ge10", 64'((c1 - c0) >= 32'd10), 64'h1);
    check("cycle_diff_bounded", 64'((c1 - c0) < 32'd1000), 64'h1);
    check("rdcycleh_zero", dm(9), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
